uart_rx: RTL and testbench

Serial receiver on the far end of the UART link; consumes the TX line produced by the team's transmitter. Recovers 11-bit frames (start, 8 data LSB-first, even parity, stop) at a fixed 16 Clk cycles per bit, oversampled on the core clock. Presents each received byte with a one-cycle valid strobe and per-frame error flags to the downstream consumer (register file / RX FIFO).

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_sync.sv | 30 +++
 rtl/uart_rx.sv | 144 ++++++++++++++
 tb/tb_uart_rx.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, FSM encoding, parity helper.
// Used by both the transmitter and the receiver of the link.
package uart_pkg;

  localparam int OVERSAMPLE   = 16;
  localparam int SAMPLE_POINT = 7;
  localparam int DATA_BITS    = 8;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  // Even parity: the parity bit that makes the total count of ones even.
  function automatic logic parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// RX line synchronizer plus one history flop for falling-edge detection.
// Line idles high, so every flop comes out of reset at 1.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic rx_i,
  output logic rx_s,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the raw line through the chain; remember the last synced value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];
  assign fall = prev_q & ~rx_s;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB-first, even parity, 1 stop bit,
// 16 clocks per bit, sampled mid-bit; one-cycle strobe per frame.
import uart_pkg::*;

module uart_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 Clear,
  input  logic                 RX,
  output logic [DATA_BITS-1:0] OutData,
  output logic                 DataValid,
  output logic                 ParityErr,
  output logic                 FrameErr,
  output logic                 Busy
);

  localparam logic [3:0] SAMPLE_CNT = 4'(SAMPLE_POINT);
  localparam logic [3:0] BIT_END    = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] LAST_BIT   = 3'(DATA_BITS - 1);

  logic rx_s;
  logic fall;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i (Clk),
    .rst_ni(Rst_n),
    .rx_i  (RX),
    .rx_s  (rx_s),
    .fall  (fall)
  );

  logic [2:0]           state_q, state_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [2:0]           data_cnt_q, data_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [DATA_BITS-1:0] out_q, out_d;
  logic                 dv_q, dv_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;

  logic sample;
  logic bit_end;

  assign sample  = (bit_cnt_q == SAMPLE_CNT);
  assign bit_end = (bit_cnt_q == BIT_END);

  // Frame FSM, counters and output register next-state.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q + 4'd1;
    data_cnt_d = data_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    out_d      = out_q;
    dv_d       = 1'b0;
    perr_d     = perr_q;
    ferr_d     = ferr_q;

    unique case (state_q)
      IDLE: begin
        bit_cnt_d  = 4'd0;
        data_cnt_d = 3'd0;
        if (fall) state_d = START;
      end
      START: begin
        if (sample && rx_s) state_d = IDLE;
        else if (bit_end)   state_d = DATA;
      end
      DATA: begin
        if (sample) shift_d[data_cnt_q] = rx_s;
        if (bit_end) begin
          data_cnt_d = data_cnt_q + 3'd1;
          if (data_cnt_q == LAST_BIT) state_d = PARITY;
        end
      end
      PARITY: begin
        if (sample)  par_d   = rx_s;
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        // Leave mid stop bit so a back-to-back start edge is not missed.
        if (sample) begin
          state_d = IDLE;
          out_d   = shift_q;
          perr_d  = par_q ^ parity(shift_q);
          ferr_d  = ~rx_s;
          dv_d    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (Clear) begin
      state_d    = IDLE;
      bit_cnt_d  = 4'd0;
      data_cnt_d = 3'd0;
      shift_d    = '0;
      par_d      = 1'b0;
      out_d      = '0;
      dv_d       = 1'b0;
      perr_d     = 1'b0;
      ferr_d     = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 4'd0;
      data_cnt_q <= 3'd0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      out_q      <= '0;
      dv_q       <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      data_cnt_q <= data_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      out_q      <= out_d;
      dv_q       <= dv_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  assign OutData   = out_q;
  assign DataValid = dv_q;
  assign ParityErr = perr_q;
  assign FrameErr  = ferr_q;
  assign Busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames driven at 16 clocks/bit,
// strobes logged on the falling clock edge and compared to constants.
module tb_uart_rx;

  logic       Clk;
  logic       Rst_n;
  logic       Clear;
  logic       RX;
  logic [7:0] OutData;
  logic       DataValid;
  logic       ParityErr;
  logic       FrameErr;
  logic       Busy;

  int n_chk  = 0;
  int n_fail = 0;

  uart_rx #(
    .SYNC_STAGES(2)
  ) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .Clear    (Clear),
    .RX       (RX),
    .OutData  (OutData),
    .DataValid(DataValid),
    .ParityErr(ParityErr),
    .FrameErr (FrameErr),
    .Busy     (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int         cyc        = 0;
  int         busy_rises = 0;
  int         busy_t     = 0;
  int         dv_cnt     = 0;
  int         dv_high    = 0;
  int         lat        = 0;
  logic       busy_prev  = 1'b0;
  logic       dv_prev    = 1'b0;
  logic [9:0] log_q[$];

  always @(negedge Clk) begin
    cyc = cyc + 1;
    if (Busy && !busy_prev) begin
      busy_rises = busy_rises + 1;
      busy_t     = cyc;
    end
    if (DataValid) begin
      dv_high = dv_high + 1;
      if (!dv_prev) begin
        dv_cnt = dv_cnt + 1;
        lat    = cyc - busy_t;
        log_q.push_back({FrameErr, ParityErr, OutData});
      end
    end
    busy_prev = Busy;
    dv_prev   = DataValid;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] ent(input int idx);
    if (idx < 0 || idx >= log_q.size()) return 10'h3ff;
    return log_q[idx];
  endfunction

  task automatic idle(input int n);
    RX = 1'b1;
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p,
                            input logic s);
    logic [10:0] f;
    f = {s, p, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      RX = f[i];
      repeat (16) @(posedge Clk);
      #1;
    end
  endtask

  int base;
  int brise;

  initial begin
    Rst_n = 1'b0;
    Clear = 1'b0;
    RX    = 1'b1;
    repeat (5) @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    chk("rst_data",  32'(OutData),   32'h00);
    chk("rst_dv",    32'(DataValid), 32'h0);
    chk("rst_perr",  32'(ParityErr), 32'h0);
    chk("rst_ferr",  32'(FrameErr),  32'h0);
    chk("rst_busy",  32'(Busy),      32'h0);
    idle(10);

    // Clean frame 0xA5: parity 0, stop 1
    base = dv_cnt;
    send_frame(8'hA5, 1'b0, 1'b1);
    idle(40);
    chk("a5_cnt",  32'(dv_cnt - base), 32'd1);
    chk("a5_ent",  32'(ent(base)),     32'h0A5);
    chk("a5_lat",  32'(lat),           32'd168);
    chk("a5_hold", 32'(OutData),       32'hA5);
    chk("a5_busy", 32'(Busy),          32'h0);

    // 0x01 with wrong parity bit 0
    base = dv_cnt;
    send_frame(8'h01, 1'b0, 1'b1);
    idle(40);
    chk("p01_cnt", 32'(dv_cnt - base), 32'd1);
    chk("p01_ent", 32'(ent(base)),     32'h101);
    chk("p01_perr", 32'(ParityErr),    32'h1);

    // 0x3C with stop 0, then break for 40 bit times
    base = dv_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    RX = 1'b0;
    repeat (40 * 16) @(posedge Clk);
    #1;
    chk("brk_cnt", 32'(dv_cnt - base), 32'd1);
    chk("brk_ent", 32'(ent(base)),     32'h23C);
    chk("brk_busy", 32'(Busy),         32'h0);
    idle(48);
    chk("brk_quiet", 32'(dv_cnt - base), 32'd1);
    chk("brk_ferr_hold", 32'(FrameErr),  32'h1);
    base = dv_cnt;
    send_frame(8'h5A, 1'b0, 1'b1);
    idle(40);
    chk("rec_cnt", 32'(dv_cnt - base), 32'd1);
    chk("rec_ent", 32'(ent(base)),     32'h05A);

    // 4-clock glitch: false start
    base  = dv_cnt;
    brise = busy_rises;
    RX = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    idle(40);
    chk("gl_busy_pulse", 32'(busy_rises - brise), 32'd1);
    chk("gl_no_dv",      32'(dv_cnt - base),      32'd0);
    chk("gl_busy",       32'(Busy),               32'h0);

    // Back-to-back 0x55 then 0xAA
    base = dv_cnt;
    send_frame(8'h55, 1'b0, 1'b1);
    send_frame(8'hAA, 1'b0, 1'b1);
    idle(40);
    chk("b2b_cnt", 32'(dv_cnt - base), 32'd2);
    chk("b2b_e0",  32'(ent(base)),     32'h055);
    chk("b2b_e1",  32'(ent(base + 1)), 32'h0AA);

    // Clear mid-DATA after 3 bits
    base = dv_cnt;
    RX = 1'b0;
    repeat (16) @(posedge Clk);
    #1;
    RX = 1'b1;
    repeat (16) @(posedge Clk);
    #1;
    RX = 1'b0;
    repeat (16) @(posedge Clk);
    #1;
    RX = 1'b1;
    repeat (24) @(posedge Clk);
    #1;
    chk("clr_pre_busy", 32'(Busy), 32'h1);
    Clear = 1'b1;
    @(posedge Clk);
    #1;
    Clear = 1'b0;
    @(negedge Clk);
    chk("clr_busy", 32'(Busy),      32'h0);
    chk("clr_data", 32'(OutData),   32'h00);
    chk("clr_dv",   32'(DataValid), 32'h0);
    chk("clr_perr", 32'(ParityErr), 32'h0);
    chk("clr_ferr", 32'(FrameErr),  32'h0);
    idle(200);
    chk("clr_no_dv", 32'(dv_cnt - base), 32'd0);
    send_frame(8'hFF, 1'b0, 1'b1);
    idle(40);
    chk("ff_cnt", 32'(dv_cnt - base), 32'd1);
    chk("ff_ent", 32'(ent(base)),     32'h0FF);

    chk("strobe_width", 32'(dv_high), 32'(dv_cnt));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
